// File: rtl/quat_sad_sel.sv
// Quarter-pel cost and decision stage: accumulates nine candidate SADs over a
// block, scans them and presents the winning index and its SAD.
module quat_sad_sel #(
  parameter int PIX_W = 8,
  parameter int BEATS = 16,
  localparam int ACC_W = PIX_W + $clog2(BEATS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_last,
  input  logic [PIX_W-1:0]   cur_pix,
  input  logic [9*PIX_W-1:0] quat,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3:0]         best_idx,
  output logic [ACC_W-1:0]   best_sad,
  output logic               frame_err
);

  localparam int BW = $clog2(BEATS);

  typedef enum logic [1:0] {ACC, CMP, OUT} state_t;

  state_t           state;
  logic [ACC_W-1:0] acc [9];
  logic [PIX_W-1:0] absd [9];
  logic [BW-1:0]    bcnt;
  logic [3:0]       scnt;
  logic             accept;
  logic             last_beat;
  logic             take;
  logic [ACC_W-1:0] scan_sad;
  logic [ACC_W-1:0] ref_sad;
  logic [3:0]       ref_idx;

  assign in_ready  = (state == ACC);
  assign out_valid = (state == OUT);
  assign accept    = in_valid && in_ready;
  assign last_beat = (bcnt == BW'(BEATS - 1));

  always_comb begin
    for (int k = 0; k < 9; k++) begin
      if (quat[k*PIX_W +: PIX_W] >= cur_pix)
        absd[k] = quat[k*PIX_W +: PIX_W] - cur_pix;
      else
        absd[k] = cur_pix - quat[k*PIX_W +: PIX_W];
    end
  end

  // The first scan step compares against the centre directly, so the centre
  // seeds the running best and wins every tie it takes part in.
  always_comb begin
    scan_sad = acc[0];
    for (int k = 1; k < 9; k++) begin
      if (scnt == 4'(k))
        scan_sad = acc[k];
    end
    ref_sad = (scnt == 4'd0) ? acc[4] : best_sad;
    ref_idx = (scnt == 4'd0) ? 4'd4 : best_idx;
    take    = (scan_sad < ref_sad);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACC;
      bcnt      <= '0;
      scnt      <= '0;
      best_idx  <= 4'd4;
      best_sad  <= '0;
      frame_err <= 1'b0;
      for (int k = 0; k < 9; k++)
        acc[k] <= '0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        ACC: begin
          if (accept) begin
            for (int k = 0; k < 9; k++)
              acc[k] <= acc[k] + ACC_W'(absd[k]);
            bcnt      <= bcnt + BW'(1);
            frame_err <= (in_last != last_beat);
            if (last_beat)
              state <= CMP;
          end
        end
        CMP: begin
          best_idx <= take ? scnt : ref_idx;
          best_sad <= take ? scan_sad : ref_sad;
          if (scnt == 4'd8)
            state <= OUT;
          else
            scnt <= scnt + 4'd1;
        end
        OUT: begin
          if (out_ready) begin
            for (int k = 0; k < 9; k++)
              acc[k] <= '0;
            scnt  <= '0;
            state <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_quat_sad_sel.sv
// Directed bench for quat_sad_sel: a block-level SAD/decision model is checked
// every cycle, and literal results pin each directed block.
`timescale 1ns/1ps
module tb_quat_sad_sel;
  localparam int PIX_W = 8;
  localparam int BEATS = 16;
  localparam int ACC_W = 12;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_last = 1'b0;
  logic             out_ready = 1'b1;
  logic [7:0]       cur_pix = '0;
  logic [71:0]      quat = '0;
  logic             in_ready;
  logic             out_valid;
  logic             frame_err;
  logic [3:0]       best_idx;
  logic [ACC_W-1:0] best_sad;

  quat_sad_sel #(.PIX_W(PIX_W), .BEATS(BEATS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .cur_pix(cur_pix), .quat(quat), .out_valid(out_valid),
    .out_ready(out_ready), .best_idx(best_idx), .best_sad(best_sad),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] blk_cur [16];
  logic [7:0] blk_q [16][9];
  int qv [9];

  int m_sum [9];
  int m_beat = 0;
  int m_phase = 0;
  int m_wait = 0;
  int m_idx = 4;
  int m_sad = 0;
  logic m_fe = 1'b0;

  int done_count = 0;
  int consumed = 0;
  int got_idx [64];
  int got_sad [64];
  int fe_pulses = 0;

  task automatic check_output(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic report_timeout(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: timed out waiting at %0t", name, $time);
  endtask

  // Spec-level model: sum |cand - cur| per candidate over 16 accepted beats,
  // pick the minimum (centre wins ties, else lowest index), then expect the
  // result 10 cycles after the final beat until it is taken.
  always @(negedge clk) begin
    if (!rst_n) begin
      check_output("reset_in_ready", in_ready, 1);
      check_output("reset_out_valid", out_valid, 0);
      check_output("reset_best_idx", best_idx, 4);
      check_output("reset_best_sad", best_sad, 0);
      check_output("reset_frame_err", frame_err, 0);
      for (int k = 0; k < 9; k++) m_sum[k] = 0;
      m_beat = 0; m_phase = 0; m_wait = 0; m_fe = 1'b0;
    end else begin
      check_output("frame_err", frame_err, m_fe);
      if (frame_err) fe_pulses++;
      m_fe = 1'b0;
      if (m_phase == 0) begin
        check_output("acc_in_ready", in_ready, 1);
        check_output("acc_out_valid", out_valid, 0);
        if (in_valid) begin
          for (int k = 0; k < 9; k++) begin
            int d;
            d = int'(quat[k*8 +: 8]) - int'(cur_pix);
            m_sum[k] += (d < 0) ? -d : d;
          end
          m_fe = (in_last != (m_beat == BEATS - 1));
          if (m_beat == BEATS - 1) begin
            int mn;
            mn = m_sum[0];
            for (int k = 1; k < 9; k++) if (m_sum[k] < mn) mn = m_sum[k];
            m_sad = mn;
            m_idx = -1;
            if (m_sum[4] == mn) m_idx = 4;
            for (int k = 0; k < 9; k++) if (m_idx < 0 && m_sum[k] == mn) m_idx = k;
            m_beat = 0; m_phase = 1; m_wait = 0;
          end else begin
            m_beat++;
          end
        end
      end else if (m_phase == 1) begin
        check_output("scan_in_ready", in_ready, 0);
        check_output("scan_out_valid", out_valid, 0);
        m_wait++;
        if (m_wait == 9) m_phase = 2;
      end else begin
        check_output("out_valid", out_valid, 1);
        check_output("out_in_ready", in_ready, 0);
        check_output("out_best_idx", best_idx, m_idx);
        check_output("out_best_sad", best_sad, m_sad);
        if (out_ready) begin
          if (done_count < 64) begin
            got_idx[done_count] = int'(best_idx);
            got_sad[done_count] = int'(best_sad);
          end
          done_count++;
          for (int k = 0; k < 9; k++) m_sum[k] = 0;
          m_phase = 0;
        end
      end
    end
  end

  task automatic fill_uniform(input int cur);
    for (int b = 0; b < 16; b++) begin
      blk_cur[b] = 8'(cur);
      for (int k = 0; k < 9; k++) blk_q[b][k] = 8'(qv[k]);
    end
  endtask

  task automatic fill_varied();
    for (int b = 0; b < 16; b++) begin
      blk_cur[b] = 8'((b * 37 + 5) % 256);
      for (int k = 0; k < 9; k++) blk_q[b][k] = 8'((b * 13 + k * 29 + 40) % 256);
    end
  endtask

  task automatic fill_ramp();
    for (int k = 0; k < 9; k++) qv[k] = 10 + k;
    fill_uniform(10);
  endtask

  // Called just after a rising edge; returns just after the edge that takes
  // the final requested beat.
  task automatic apply_stimulus(input int nbeats, input bit gaps, input logic [15:0] last_mask);
    for (int b = 0; b < nbeats; b++) begin
      int t;
      bit taken;
      if (gaps) begin
        int idle;
        idle = $urandom_range(0, 2);
        in_valid = 1'b0;
        for (int i = 0; i < idle; i++) begin
          @(posedge clk); #1;
        end
      end
      cur_pix = blk_cur[b];
      for (int k = 0; k < 9; k++) quat[k*8 +: 8] = blk_q[b][k];
      in_last = last_mask[b];
      in_valid = 1'b1;
      t = 0;
      taken = 1'b0;
      while (!taken && t < 200) begin
        @(negedge clk);
        taken = in_ready;
        @(posedge clk); #1;
        t++;
      end
      if (!taken) begin
        report_timeout("beat_accept");
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_result(input string name, input int e_idx, input int e_sad);
    int t;
    t = 0;
    while (done_count <= consumed && t < 400) begin
      @(posedge clk); #1;
      t++;
    end
    if (done_count <= consumed) begin
      report_timeout({name, "_result"});
      return;
    end
    if (e_idx >= 0) begin
      check_output({name, "_idx"}, got_idx[consumed], e_idx);
      check_output({name, "_sad"}, got_sad[consumed], e_sad);
    end
    consumed++;
  endtask

  initial begin
    int fe_base;
    int ref_res;
    int t;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    fill_ramp();
    fe_base = fe_pulses;
    apply_stimulus(16, 1'b0, 16'h8000);
    wait_result("ramp", 0, 0);
    check_output("ramp_frame_err_pulses", fe_pulses - fe_base, 0);

    for (int k = 0; k < 9; k++) qv[k] = 103;
    qv[2] = 100; qv[6] = 100;
    fill_uniform(100);
    apply_stimulus(16, 1'b0, 16'h8000);
    wait_result("tie_low", 2, 0);

    qv[4] = 100;
    fill_uniform(100);
    apply_stimulus(16, 1'b0, 16'h8000);
    wait_result("tie_centre", 4, 0);

    for (int k = 0; k < 9; k++) qv[k] = 255;
    qv[4] = 254;
    fill_uniform(0);
    apply_stimulus(16, 1'b0, 16'h8000);
    wait_result("full_254", 4, 4064);

    qv[4] = 255;
    fill_uniform(0);
    apply_stimulus(16, 1'b0, 16'h8000);
    wait_result("full_255", 4, 4080);

    fill_ramp();
    out_ready = 1'b0;
    apply_stimulus(16, 1'b0, 16'h8000);
    t = 0;
    while (t < 50) begin
      @(negedge clk);
      if (out_valid) break;
      t++;
    end
    if (t >= 50) report_timeout("backpressure_out_valid");
    repeat (5) begin
      @(negedge clk);
      check_output("bp_hold_out_valid", out_valid, 1);
      check_output("bp_hold_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_result("backpressure", 0, 0);

    for (int k = 0; k < 9; k++) qv[k] = 103;
    qv[2] = 100; qv[6] = 100;
    fill_uniform(100);
    apply_stimulus(16, 1'b0, 16'h8000);
    for (int k = 0; k < 9; k++) qv[k] = 255;
    qv[4] = 254;
    fill_uniform(0);
    apply_stimulus(16, 1'b0, 16'h8000);
    wait_result("b2b_first", 2, 0);
    wait_result("b2b_second", 4, 4064);

    fill_varied();
    apply_stimulus(16, 1'b0, 16'h8000);
    ref_res = consumed;
    wait_result("varied", -1, -1);
    fill_varied();
    apply_stimulus(16, 1'b1, 16'h8000);
    wait_result("varied_gaps", -1, -1);
    if (done_count >= 2 && ref_res + 1 < 64) begin
      check_output("gaps_vs_gapless_idx", got_idx[ref_res + 1], got_idx[ref_res]);
      check_output("gaps_vs_gapless_sad", got_sad[ref_res + 1], got_sad[ref_res]);
    end

    fill_ramp();
    fe_base = fe_pulses;
    apply_stimulus(16, 1'b0, 16'h0080);
    wait_result("frame_err_block", 0, 0);
    check_output("frame_err_pulses", fe_pulses - fe_base, 2);

    fill_varied();
    apply_stimulus(9, 1'b0, 16'h0000);
    rst_n = 1'b0;
    #1;
    check_output("async_rst_best_idx", best_idx, 4);
    check_output("async_rst_in_ready", in_ready, 1);
    check_output("async_rst_best_sad", best_sad, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    fill_ramp();
    apply_stimulus(16, 1'b0, 16'h8000);
    wait_result("after_reset", 0, 0);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
